// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised SRAM: FSM encoding, legal read latencies, parity helper.
package sram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Even parity: the stored bit makes the 9-bit lane XOR to zero.
    function automatic logic even_parity(input logic [7:0] i_byte);
        return ^i_byte;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Raw single-port storage with per-lane write enables and one registered read port.
// Lane width is supplied by the parent, so parity bits (SRAM_PARITY_EN) need no special casing here.
module sram_array
    import sram_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_waddr,
    input  logic [LANES-1:0]        i_wbe,
    input  logic [LANES*LANE_W-1:0] i_wdata,
    input  logic                    i_re,
    input  logic [ADDR_W-1:0]       i_raddr,
    output logic [LANES*LANE_W-1:0] o_rdata
);

    logic [LANES*LANE_W-1:0] r_mem [DEPTH];
    logic [LANES*LANE_W-1:0] r_rdata;

    // NOTE: the storage array has no reset; the parent's CLEAR sweep initialises it, keeping RAM inference intact.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_wbe[i]) begin
                    r_mem[i_waddr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // NOTE: non-blocking assignment here means a same-edge write is not yet visible, giving read-first behaviour.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_param.sv
// Parametrised synchronous SRAM: post-reset clear FSM, byte-enable writes, range check, 1- or 2-cycle read latency.
// Optional per-lane even parity is enabled by defining SRAM_PARITY_EN.
module sram_param
    import sram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [ADDR_W-1:0]     Address,
    input  logic                  SRAMRead,
    input  logic                  SRAMWrite,
    input  logic [DATA_W/8-1:0]   ByteEn,
    input  logic [DATA_W-1:0]     Datain,
    output logic [DATA_W-1:0]     Dataout,
    output logic                  DataValid,
    output logic                  Ready,
    output logic                  AddrErr,
    output logic                  ParityErr
);

    localparam int LANES = DATA_W / 8;
`ifdef SRAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int                STORE_W   = LANES * LANE_W;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_ready;
    logic                r_valid1;
    logic                r_oor1;
    logic                r_addr_err;

    logic                w_in_range;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [LANES-1:0]    w_wbe;
    logic [STORE_W-1:0]  w_wdata_enc;
    logic [STORE_W-1:0]  w_wdata;
    logic [STORE_W-1:0]  w_rdata;
    logic [DATA_W-1:0]   w_dout1;
    logic                w_perr1;

    assign w_in_range = ({1'b0, Address} < DEPTH_L);
    assign w_rd_ok    = r_ready & SRAMRead;
    assign w_wr_ok    = r_ready & SRAMWrite;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: r_ready <= 1'b1;
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_wdata_enc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_wdata_enc[i*LANE_W +: 8] = Datain[i*8 +: 8];
`ifdef SRAM_PARITY_EN
            w_wdata_enc[i*LANE_W + 8] = even_parity(Datain[i*8 +: 8]);
`endif
        end
    end

    // The clear sweep owns the write port until Ready; parity of an all-zero byte is zero.
    always_comb begin
        w_we    = w_wr_ok & w_in_range;
        w_waddr = Address;
        w_wbe   = ByteEn;
        w_wdata = w_wdata_enc;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wbe   = '1;
            w_wdata = '0;
        end
    end

    sram_array #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .Reset   (Reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wbe   (w_wbe),
        .i_wdata (w_wdata),
        .i_re    (w_rd_ok & w_in_range),
        .i_raddr (Address),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_valid1   <= 1'b0;
            r_oor1     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_valid1   <= w_rd_ok;
            r_addr_err <= (w_rd_ok | w_wr_ok) & ~w_in_range;
            if (w_rd_ok) begin
                r_oor1 <= ~w_in_range;
            end
        end
    end

    always_comb begin
        w_dout1 = '0;
        w_perr1 = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_dout1[i*8 +: 8] = r_oor1 ? 8'h00 : w_rdata[i*LANE_W +: 8];
`ifdef SRAM_PARITY_EN
            w_perr1 = w_perr1 | (^w_rdata[i*LANE_W +: LANE_W]);
`endif
        end
        w_perr1 = w_perr1 & r_valid1 & ~r_oor1;
    end

    if (READ_LAT == READ_LAT_MAX) begin : g_lat2
        logic [DATA_W-1:0] r_dout2;
        logic              r_valid2;
        logic              r_perr2;

        always_ff @(posedge clk or posedge Reset) begin
            if (Reset) begin
                r_dout2  <= '0;
                r_valid2 <= 1'b0;
                r_perr2  <= 1'b0;
            end else begin
                r_valid2 <= r_valid1;
                if (r_valid1) begin
                    r_dout2 <= w_dout1;
                    r_perr2 <= w_perr1;
                end
            end
        end

        assign Dataout   = r_dout2;
        assign DataValid = r_valid2;
        assign ParityErr = r_valid2 & r_perr2;
    end else begin : g_lat1
        assign Dataout   = w_dout1;
        assign DataValid = r_valid1;
        assign ParityErr = w_perr1;
    end

    assign Ready   = r_ready;
    assign AddrErr = r_addr_err;

endmodule

// File: tb/tb_sram_param.sv
// Directed self-checking bench: default 8x256 latency-1 instance and a 16x200 latency-2 instance on a shared reset.
module tb_sram_param;

    logic        clk = 1'b0;
    logic        Reset;

    logic [7:0]  a_addr;
    logic        a_rd, a_wr;
    logic [0:0]  a_be;
    logic [7:0]  a_din, a_dout;
    logic        a_valid, a_ready, a_aerr, a_perr;

    logic [7:0]  b_addr;
    logic        b_rd, b_wr;
    logic [1:0]  b_be;
    logic [15:0] b_din, b_dout;
    logic        b_valid, b_ready, b_aerr, b_perr;

    int errors = 0;
    int checks = 0;
    int n_a, n_b;

    always #5 clk = ~clk;

    sram_param dut_a (
        .clk(clk), .Reset(Reset), .Address(a_addr), .SRAMRead(a_rd), .SRAMWrite(a_wr),
        .ByteEn(a_be), .Datain(a_din), .Dataout(a_dout), .DataValid(a_valid),
        .Ready(a_ready), .AddrErr(a_aerr), .ParityErr(a_perr)
    );

    sram_param #(.DATA_W(16), .DEPTH(200), .ADDR_W(8), .READ_LAT(2)) dut_b (
        .clk(clk), .Reset(Reset), .Address(b_addr), .SRAMRead(b_rd), .SRAMWrite(b_wr),
        .ByteEn(b_be), .Datain(b_din), .Dataout(b_dout), .DataValid(b_valid),
        .Ready(b_ready), .AddrErr(b_aerr), .ParityErr(b_perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1;
        a_addr = '0; a_rd = 0; a_wr = 0; a_be = '0; a_din = '0;
        b_addr = '0; b_rd = 0; b_wr = 0; b_be = '0; b_din = '0;
        repeat (3) tick();
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_a_valid", 32'(a_valid), 32'h0);
        chk("rst_a_dout",  32'(a_dout),  32'h0);
        chk("rst_a_aerr",  32'(a_aerr),  32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);
        chk("rst_b_dout",  32'(b_dout),  32'h0);

        // Requests during clear must be ignored
        Reset = 1'b0;
        a_rd = 1; a_wr = 1; a_addr = 8'd5; a_din = 8'hFF; a_be = 1'b1;
        tick();
        a_rd = 0; a_wr = 0;
        chk("clr_ignore_valid", 32'(a_valid), 32'h0);
        chk("clr_ignore_aerr",  32'(a_aerr),  32'h0);
        repeat (99) tick();
        chk("clr_mid_ready", 32'(a_ready), 32'h0);

        // Reset at count 100 restarts the sweep from zero
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_a = 0;
        n_b = 0;
        while (n_a < 400 && !a_ready) begin
            tick();
            n_a++;
            if (b_ready && n_b == 0) n_b = n_a;
        end
        chk("ready_latency_a", 32'(n_a), 32'd256);
        chk("ready_latency_b", 32'(n_b), 32'd200);

        // Cleared word reads back zero with a one-cycle pulse
        a_addr = 8'd20; a_rd = 1;
        tick();
        a_rd = 0;
        chk("rd20_valid", 32'(a_valid), 32'h1);
        chk("rd20_dout",  32'(a_dout),  32'h0);
        chk("rd20_perr",  32'(a_perr),  32'h0);
        tick();
        chk("rd20_valid_drop", 32'(a_valid), 32'h0);

        // Writes then back-to-back reads
        a_wr = 1; a_be = 1'b1; a_addr = 8'd5; a_din = 8'hA5;
        tick();
        a_addr = 8'd10; a_din = 8'h3C;
        tick();
        a_wr = 0; a_rd = 1; a_addr = 8'd5;
        tick();
        chk("b2b_dout0",  32'(a_dout),  32'hA5);
        chk("b2b_valid0", 32'(a_valid), 32'h1);
        a_addr = 8'd10;
        tick();
        a_rd = 0;
        chk("b2b_dout1",  32'(a_dout),  32'h3C);
        chk("b2b_valid1", 32'(a_valid), 32'h1);
        tick();
        chk("b2b_valid_end", 32'(a_valid), 32'h0);
        chk("dout_hold",     32'(a_dout),  32'h3C);

        // Same-edge read and write is read-first
        a_wr = 1; a_addr = 8'd7; a_din = 8'h11;
        tick();
        a_rd = 1; a_din = 8'h22;
        tick();
        a_wr = 0; a_rd = 0;
        chk("rw_read_first", 32'(a_dout), 32'h11);
        a_rd = 1;
        tick();
        a_rd = 0;
        chk("rw_new_value", 32'(a_dout), 32'h22);

`ifdef SRAM_PARITY_EN
        dut_a.u_array.r_mem[5][0] = ~dut_a.u_array.r_mem[5][0];
        a_rd = 1; a_addr = 8'd5;
        tick();
        a_rd = 0;
        chk("perr_flag",  32'(a_perr),  32'h1);
        chk("perr_valid", 32'(a_valid), 32'h1);
        tick();
        chk("perr_drop", 32'(a_perr), 32'h0);
`endif

        // Byte enables on the 16-bit, latency-2 instance
        b_wr = 1; b_addr = 8'd3; b_din = 16'h1234; b_be = 2'b11;
        tick();
        b_din = 16'hABCD; b_be = 2'b10;
        tick();
        b_wr = 0; b_rd = 1;
        tick();
        b_rd = 0;
        chk("lat2_not_yet", 32'(b_valid), 32'h0);
        tick();
        chk("lat2_valid", 32'(b_valid), 32'h1);
        chk("byteen_dout", 32'(b_dout), 32'hAB34);
        tick();
        chk("lat2_valid_drop", 32'(b_valid), 32'h0);

        // Out-of-range write and read
        b_wr = 1; b_addr = 8'd210; b_din = 16'h0077; b_be = 2'b11;
        tick();
        b_wr = 0;
        chk("oor_wr_aerr", 32'(b_aerr), 32'h1);
        tick();
        chk("oor_wr_aerr_drop", 32'(b_aerr), 32'h0);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("oor_rd_aerr", 32'(b_aerr), 32'h1);
        tick();
        chk("oor_rd_valid", 32'(b_valid), 32'h1);
        chk("oor_rd_dout",  32'(b_dout),  32'h0);
        chk("oor_rd_perr",  32'(b_perr),  32'h0);

        // Last legal address behaves normally
        b_wr = 1; b_addr = 8'd199; b_din = 16'h5A5A;
        tick();
        b_wr = 0;
        chk("wr199_aerr", 32'(b_aerr), 32'h0);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("rd199_aerr", 32'(b_aerr), 32'h0);
        tick();
        chk("rd199_valid", 32'(b_valid), 32'h1);
        chk("rd199_dout",  32'(b_dout),  32'h5A5A);

        // Reset while a latency-2 read is in flight
        b_rd = 1; b_addr = 8'd3;
        tick();
        b_rd = 0;
        Reset = 1'b1;
        #1;
        chk("rst_inflight_valid0", 32'(b_valid), 32'h0);
        tick();
        chk("rst_inflight_valid1", 32'(b_valid), 32'h0);
        chk("rst_inflight_dout",   32'(b_dout),  32'h0);
        chk("rst_a_ready_again",   32'(a_ready), 32'h0);
        Reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
